// File: rtl/input_pkg.sv
// Shared constants for the DE2-115 pushbutton/slider-switch input conditioning.
package input_pkg;

  localparam int DEF_TICK_DIV     = 50000;
  localparam int DEF_STABLE_TICKS = 20;

  localparam int KEY_W = 4;
  localparam int SW_W  = 18;

  localparam logic [KEY_W-1:0] KEY_IDLE = '1;
  localparam logic [SW_W-1:0]  SW_IDLE  = '0;

  // Counter width able to hold 0..n.
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/debounce_bit.sv
// One input bit: 2-FF synchroniser, tick-based stability counter and debounced level
// with registered rise/fall pulses coincident with the level update.
module debounce_bit
  import input_pkg::*;
#(
  parameter logic RST_LEVEL    = 1'b0,
  parameter int   STABLE_TICKS = DEF_STABLE_TICKS
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic raw,
  output logic db,
  output logic rise,
  output logic fall
);

  localparam int            CW       = cnt_width(STABLE_TICKS);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_TICKS - 1);

  logic          sync1_reg;
  logic          sync2_reg;
  logic          db_reg;
  logic          rise_reg;
  logic          fall_reg;
  logic [CW-1:0] cnt_reg;
  logic [CW-1:0] cnt_next;
  logic          accept;

  // Any cycle in which the synchronised pin agrees with the level clears the count.
  always_comb begin
    cnt_next = cnt_reg;
    accept   = 1'b0;
    if (sync2_reg == db_reg) begin
      cnt_next = '0;
    end else if (tick) begin
      if (cnt_reg == CNT_LAST) begin
        accept   = 1'b1;
        cnt_next = '0;
      end else begin
        cnt_next = cnt_reg + CW'(1);
      end
    end
  end

  // Synchroniser resets to the idle level so release does not look like an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg <= RST_LEVEL;
      sync2_reg <= RST_LEVEL;
      db_reg    <= RST_LEVEL;
      cnt_reg   <= '0;
      rise_reg  <= 1'b0;
      fall_reg  <= 1'b0;
    end else begin
      sync1_reg <= raw;
      sync2_reg <= sync1_reg;
      cnt_reg   <= cnt_next;
      if (accept) begin
        db_reg <= sync2_reg;
      end
      rise_reg <= accept & sync2_reg;
      fall_reg <= accept & ~sync2_reg;
    end
  end

  assign db   = db_reg;
  assign rise = rise_reg;
  assign fall = fall_reg;

endmodule

// File: rtl/input_debouncer.sv
// Debounces the raw KEY and SW pins against a shared prescaler tick and provides
// one-cycle press/release/change pulses alongside the debounced levels.
module input_debouncer
  import input_pkg::*;
#(
  parameter int TICK_DIV     = DEF_TICK_DIV,
  parameter int STABLE_TICKS = DEF_STABLE_TICKS,
  parameter int N_KEYS       = KEY_W,
  parameter int N_SW         = SW_W
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic [N_KEYS-1:0] key_raw_n,
  input  logic [N_SW-1:0]   sw_raw,
  output logic [N_KEYS-1:0] key_db,
  output logic [N_SW-1:0]   sw_db,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic [N_SW-1:0]   sw_changed
);

  localparam int            PW        = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_TOP = PW'(TICK_DIV - 1);

  logic [PW-1:0]   presc_reg;
  logic            tick;
  logic [N_SW-1:0] sw_rise;
  logic [N_SW-1:0] sw_fall;

  assign tick = (presc_reg == PRESC_TOP);

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      presc_reg <= '0;
    end else if (tick) begin
      presc_reg <= '0;
    end else begin
      presc_reg <= presc_reg + PW'(1);
    end
  end

  // Keys are active-low: a falling level is a press.
  generate
    for (genvar gi = 0; gi < N_KEYS; gi++) begin : g_key
      debounce_bit #(
        .RST_LEVEL    (KEY_IDLE[0]),
        .STABLE_TICKS (STABLE_TICKS)
      ) u_key (
        .clk   (clk_clk),
        .rst_n (reset_reset_n),
        .tick  (tick),
        .raw   (key_raw_n[gi]),
        .db    (key_db[gi]),
        .rise  (key_release[gi]),
        .fall  (key_press[gi])
      );
    end

    for (genvar gi = 0; gi < N_SW; gi++) begin : g_sw
      debounce_bit #(
        .RST_LEVEL    (SW_IDLE[0]),
        .STABLE_TICKS (STABLE_TICKS)
      ) u_sw (
        .clk   (clk_clk),
        .rst_n (reset_reset_n),
        .tick  (tick),
        .raw   (sw_raw[gi]),
        .db    (sw_db[gi]),
        .rise  (sw_rise[gi]),
        .fall  (sw_fall[gi])
      );
    end
  endgenerate

  assign sw_changed = sw_rise | sw_fall;

endmodule
